// File: rtl/pkt_rr_demux_pkg.sv
// Shared types and width helper for the round-robin packet demultiplexer.
package pkt_rr_demux_pkg;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Never returns zero, so single-value counters still get a 1-bit register.
    function automatic int clog2w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pkt_rr_demux_rr_pick.sv
// Rotating-priority search: first set bit of req at ptr, ptr+1, ... modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [N-1:0][IW-1:0] cand;

    // N need not be a power of two, so the wrap is an explicit compare-subtract.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int unsigned b);
        logic [IW:0] s;
        s = {1'b0, a} + (IW+1)'(b);
        if (s >= (IW+1)'(N))
            s = s - (IW+1)'(N);
        return s[IW-1:0];
    endfunction

    for (genvar k = 0; k < N; k++) begin : g_cand
        assign cand[k] = wrap_add(ptr, k);
    end

    // Scan farthest offset first so the nearest requester is the last writer.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                found = 1'b1;
                idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/pkt_rr_demux.sv
// Packet demultiplexer: grants whole packets to downstream channels in
// round-robin order through one shared, registered output beat.
module pkt_rr_demux
    import pkt_rr_demux_pkg::*;
#(
    parameter int W             = 534,
    parameter int NUM_CH        = 16,
    parameter int BEATS_PER_PKT = 25,
    parameter int SKIP_BUSY     = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [W-1:0]              in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [W-1:0]              out_data,
    output logic [NUM_CH-1:0]         out_valid,
    output logic                      out_sop,
    output logic                      out_eop,
    input  logic [NUM_CH-1:0]         out_ready,
    output logic [clog2w(NUM_CH)-1:0] cur_ch,
    output logic                      pkt_done
);

    localparam int CH_W  = clog2w(NUM_CH);
    localparam int CNT_W = clog2w(BEATS_PER_PKT + 1);
    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_PKT - 1);

    typedef struct packed {
        logic [W-1:0] data;
        logic         sop;
        logic         eop;
    } beat_t;

    state_t            state, state_nxt;
    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   gnt_ch;
    logic              gnt_ok;
    logic [CNT_W-1:0]  beat_cnt;
    logic              last_in;
    beat_t             out_beat;
    logic              out_vld_reg;
    logic              up_acc;
    logic              dn_acc;

    if (SKIP_BUSY != 0) begin : g_skip
        rr_pick #(.N(NUM_CH), .IW(CH_W)) u_pick (
            .req   (out_ready),
            .ptr   (ptr),
            .found (gnt_ok),
            .idx   (gnt_ch)
        );
    end else begin : g_fixed
        assign gnt_ok = 1'b1;
        assign gnt_ch = ptr;
    end

    assign last_in = (beat_cnt == LAST_BEAT);
    assign dn_acc  = out_vld_reg && out_ready[cur_ch];
    assign up_acc  = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_ARB;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        pkt_done  = 1'b0;
        case (state)
            ST_ARB: begin
                if (gnt_ok)
                    state_nxt = ST_XFER;
            end
            ST_XFER: begin
                // Output register empties and refills in the same cycle.
                in_ready = !out_vld_reg || out_ready[cur_ch];
                if (in_valid && in_ready && last_in)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (dn_acc && out_beat.eop) begin
                    pkt_done  = 1'b1;
                    state_nxt = ST_ARB;
                end
            end
            default: state_nxt = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            cur_ch   <= '0;
            beat_cnt <= '0;
        end else begin
            if (state == ST_ARB && gnt_ok) begin
                cur_ch   <= gnt_ch;
                beat_cnt <= '0;
            end
            if (up_acc)
                beat_cnt <= last_in ? '0 : beat_cnt + 1'b1;
            if (pkt_done)
                ptr <= (cur_ch == LAST_CH) ? '0 : cur_ch + 1'b1;
        end
    end

    // Beat register holds until accepted; sop/eop are frozen with the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_beat    <= '0;
            out_vld_reg <= 1'b0;
        end else if (up_acc) begin
            out_beat    <= '{data: in_data, sop: (beat_cnt == '0), eop: last_in};
            out_vld_reg <= 1'b1;
        end else if (dn_acc) begin
            out_vld_reg <= 1'b0;
        end
    end

    assign out_data = out_beat.data;
    assign out_sop  = out_vld_reg && out_beat.sop;
    assign out_eop  = out_vld_reg && out_beat.eop;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ov
        assign out_valid[i] = out_vld_reg && (cur_ch == CH_W'(i));
    end

endmodule

// File: tb/tb_pkt_rr_demux.sv
// Directed bench: three instances (skip-busy 4ch, strict 4ch, skip-busy 3ch/1-beat).
module tb_pkt_rr_demux;

    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]          rst;
    logic [2:0][DW-1:0]  in_data;
    logic [2:0][DW-1:0]  out_data;
    logic [2:0]          in_valid, in_ready, out_sop, out_eop, pkt_done;
    logic [2:0][3:0]     out_valid;
    logic [2:0][3:0]     out_ready;
    logic [2:0][1:0]     cur_ch;

    pkt_rr_demux #(.W(DW), .NUM_CH(4), .BEATS_PER_PKT(3), .SKIP_BUSY(1)) dut_a (
        .clk(clk), .rst(rst[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .out_data(out_data[0]), .out_valid(out_valid[0]),
        .out_sop(out_sop[0]), .out_eop(out_eop[0]), .out_ready(out_ready[0]),
        .cur_ch(cur_ch[0]), .pkt_done(pkt_done[0]));

    pkt_rr_demux #(.W(DW), .NUM_CH(4), .BEATS_PER_PKT(3), .SKIP_BUSY(0)) dut_b (
        .clk(clk), .rst(rst[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .out_data(out_data[1]), .out_valid(out_valid[1]),
        .out_sop(out_sop[1]), .out_eop(out_eop[1]), .out_ready(out_ready[1]),
        .cur_ch(cur_ch[1]), .pkt_done(pkt_done[1]));

    pkt_rr_demux #(.W(DW), .NUM_CH(3), .BEATS_PER_PKT(1), .SKIP_BUSY(1)) dut_c (
        .clk(clk), .rst(rst[2]), .in_data(in_data[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .out_data(out_data[2]), .out_valid(out_valid[2][2:0]),
        .out_sop(out_sop[2]), .out_eop(out_eop[2]), .out_ready(out_ready[2][2:0]),
        .cur_ch(cur_ch[2]), .pkt_done(pkt_done[2]));

    assign out_valid[2][3] = 1'b0;

    typedef struct { int d; int ch; bit sop; bit eop; int cyc; } rec_t;

    rec_t          lg [3][$];
    int            pk [3][$];
    int            ncyc;
    int            n_bad_oh [3];
    int            n_unstable [3];
    int            n_irdy [3];
    int            n_bad_done [3];
    logic [DW-1:0] held_d [3];
    bit            held [3];
    int            checks, errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe all DUTs at negedge, then advance upstream data after posedge.
    task automatic tick();
        bit up [3];
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            logic [3:0] acc;
            up[i] = in_valid[i] && in_ready[i];
            acc   = out_valid[i] & out_ready[i];
            if (out_valid[i] != 4'd0 && out_valid[i] != (4'b1 << cur_ch[i])) n_bad_oh[i]++;
            if (held[i] && out_data[i] != held_d[i]) n_unstable[i]++;
            held[i]   = (out_valid[i] != 4'd0) && (acc == 4'd0);
            held_d[i] = out_data[i];
            if (in_ready[i]) n_irdy[i]++;
            if (acc != 4'd0)
                lg[i].push_back('{d: int'(out_data[i]), ch: int'(cur_ch[i]),
                                  sop: out_sop[i], eop: out_eop[i], cyc: ncyc});
            if (pkt_done[i]) begin
                pk[i].push_back(int'(cur_ch[i]));
                if (!(acc != 4'd0 && out_eop[i])) n_bad_done[i]++;
            end
        end
        @(posedge clk);
        #1;
        ncyc++;
        for (int i = 0; i < 3; i++)
            if (up[i]) in_data[i] = in_data[i] + 1'b1;
    endtask

    task automatic wait_pkts(input int i, input int n, input int budget, input string tag);
        int t = 0;
        while (pk[i].size() < n && t < budget) begin
            tick();
            t++;
        end
        chk(tag, pk[i].size(), n);
    endtask

    task automatic clr(input int i);
        lg[i].delete();
        pk[i].delete();
    endtask

    initial begin
        int base;
        int exp_ch [5];
        checks = 0; errors = 0; ncyc = 0;
        for (int i = 0; i < 3; i++) begin
            n_bad_oh[i] = 0; n_unstable[i] = 0; n_irdy[i] = 0; n_bad_done[i] = 0;
            held[i] = 0; held_d[i] = '0;
        end
        rst = 3'b111; in_valid = '0; in_data = '0; out_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cur_ch", cur_ch, 0);
        chk("rst_flags", {out_sop, out_eop, pkt_done}, 0);
        chk("rst_out_data", out_data, 0);

        // 8 packets, all ready, continuous valid
        rst[0] = 1'b0; out_ready[0] = 4'hF; in_valid[0] = 1'b1;
        clr(0);
        wait_pkts(0, 8, 200, "p1_pkts");
        chk("p1_beats", lg[0].size(), 24);
        for (int k = 0; k < 24 && k < lg[0].size(); k++) begin
            chk("p1_ch", lg[0][k].ch, (k / 3) % 4);
            chk("p1_data", lg[0][k].d, k);
            chk("p1_sop", lg[0][k].sop, (k % 3) == 0);
            chk("p1_eop", lg[0][k].eop, (k % 3) == 2);
            if (k % 3 != 0) chk("p1_gap", lg[0][k].cyc - lg[0][k-1].cyc, 1);
        end
        for (int j = 0; j < 8 && j < pk[0].size(); j++) chk("p1_pk_ch", pk[0][j], j % 4);

        // skip-busy from ptr=2 with channel 2 not ready
        clr(0);
        wait_pkts(0, 2, 50, "p2_pre");
        out_ready[0] = 4'b1011;
        wait_pkts(0, 5, 100, "p2_pkts");
        exp_ch = '{0, 1, 3, 0, 1};
        for (int j = 0; j < 5 && j < pk[0].size(); j++) chk("p2_pk_ch", pk[0][j], exp_ch[j]);
        begin
            int n2 = 0;
            foreach (lg[0][k]) if (lg[0][k].ch == 2) n2++;
            chk("p2_no_ch2", n2, 0);
        end

        // toggling ready: no loss, no duplication, stable while stalled
        clr(0);
        base = int'(in_data[0]);
        n_unstable[0] = 0;
        for (int t = 0; t < 400 && pk[0].size() < 4; t++) begin
            out_ready[0] = (ncyc % 2 == 1) ? 4'hF : 4'h0;
            tick();
        end
        chk("p3_beats", lg[0].size(), 12);
        for (int k = 0; k < 12 && k < lg[0].size(); k++) begin
            chk("p3_data", lg[0][k].d, base + k);
            chk("p3_sop", lg[0][k].sop, (k % 3) == 0);
            chk("p3_eop", lg[0][k].eop, (k % 3) == 2);
        end
        exp_ch = '{2, 3, 0, 1, 0};
        for (int j = 0; j < 4 && j < pk[0].size(); j++) chk("p3_pk_ch", pk[0][j], exp_ch[j]);
        chk("p3_stable", n_unstable[0], 0);

        // reset mid-packet on channel 2
        out_ready[0] = 4'hF;
        for (int t = 0; t < 20; t++) begin
            if (out_valid[0] != 4'd0 && !out_sop[0] && cur_ch[0] == 2'd2) break;
            tick();
        end
        chk("p4_pre_ch", cur_ch[0], 2);
        chk("p4_pre_valid", out_valid[0], 4'b0100);
        #2;
        rst[0] = 1'b1;
        #1;
        chk("p4_rst_valid", out_valid[0], 0);
        chk("p4_rst_flags", {out_sop[0], out_eop[0], pkt_done[0], in_ready[0]}, 0);
        chk("p4_rst_data", out_data[0], 0);
        chk("p4_rst_cur", cur_ch[0], 0);
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        held[0] = 0;
        clr(0);
        wait_pkts(0, 1, 50, "p4_pkts");
        chk("p4_beats", lg[0].size(), 3);
        if (lg[0].size() > 0) begin
            chk("p4_first_ch", lg[0][0].ch, 0);
            chk("p4_first_sop", lg[0][0].sop, 1);
        end
        if (pk[0].size() > 0) chk("p4_pk_ch", pk[0][0], 0);

        // strict rotation waits on a busy channel
        rst[1] = 1'b0; out_ready[1] = 4'b1101; in_valid[1] = 1'b1;
        clr(1);
        wait_pkts(1, 1, 50, "p5_pre");
        clr(1);
        n_irdy[1] = 0;
        repeat (20) tick();
        chk("p5_no_beats", lg[1].size(), 0);
        chk("p5_no_done", pk[1].size(), 0);
        chk("p5_cur_ch", cur_ch[1], 1);
        chk("p5_valid", out_valid[1], 4'b0010);
        chk("p5_in_ready", n_irdy[1], 1);
        out_ready[1] = 4'hF;
        wait_pkts(1, 2, 50, "p5_pkts");
        if (pk[1].size() >= 2) begin
            chk("p5_pk0", pk[1][0], 1);
            chk("p5_pk1", pk[1][1], 2);
        end
        if (lg[1].size() > 0) chk("p5_held_data", lg[1][0].d, 3);

        // 3 channels, single-beat packets
        rst[2] = 1'b0; out_ready[2] = 4'b0111; in_valid[2] = 1'b1;
        clr(2);
        wait_pkts(2, 4, 100, "p6_pkts");
        chk("p6_beats", lg[2].size(), 4);
        exp_ch = '{0, 1, 2, 0, 0};
        for (int k = 0; k < 4 && k < lg[2].size(); k++) begin
            chk("p6_ch", lg[2][k].ch, exp_ch[k]);
            chk("p6_sop_eop", {lg[2][k].sop, lg[2][k].eop}, 2'b11);
            chk("p6_data", lg[2][k].d, k);
        end
        for (int j = 0; j < 4 && j < pk[2].size(); j++) chk("p6_pk_ch", pk[2][j], exp_ch[j]);

        for (int i = 0; i < 3; i++) begin
            chk("onehot", n_bad_oh[i], 0);
            chk("done_on_eop", n_bad_done[i], 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
